// File: rtl/ofdm_tx_pkg.sv
// Shared types and constants for the OFDM TX framing path.
// The state enum, the pilot LFSR seed/taps and a width helper live here.
package ofdm_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA
    } state_t;

    localparam logic [6:0]  LFSR_SEED   = 7'h7F;
    localparam int unsigned LFSR_TAP_HI = 6;
    localparam int unsigned LFSR_TAP_LO = 5;

    // Smallest r with 2**r >= v; usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_lfsr7.sv
// Pilot sign generator: x^7+x^6+1 Fibonacci LFSR, shift left, one step per pilot.
// bit_o is the sign of the pilot currently being emitted (1 = negative).
module tx_lfsr7
    import ofdm_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic adv,
    output logic bit_o
);

    logic [6:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (load) begin
            lfsr <= LFSR_SEED;
        end else if (adv) begin
            lfsr <= {lfsr[5:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
        end
    end

    assign bit_o = lfsr[0];

endmodule

// File: rtl/pilot_inserter.sv
// TX framer: one all-pilot preamble symbol, then FRAME_SYMS data symbols with
// comb pilots every PILOT_STEP subcarriers, through a single output register.
module pilot_inserter
    import ofdm_tx_pkg::*;
#(
    parameter int                     DW         = 16,
    parameter int                     NFFT       = 64,
    parameter int                     PILOT_STEP = 8,
    parameter int                     FRAME_SYMS = 4,
    parameter logic signed [DW-1:0]   AMP        = 16'sd8192
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [DW-1:0]           in_i,
    input  logic signed [DW-1:0]           in_q,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [DW-1:0]           out_i,
    output logic signed [DW-1:0]           out_q,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [clog2(NFFT)-1:0]         out_idx,
    output logic                           out_pilot,
    output logic                           out_pre
);

    localparam int unsigned IW = clog2(NFFT);
    localparam int unsigned SW = (clog2(FRAME_SYMS) > 0) ? clog2(FRAME_SYMS) : 1;

    localparam logic [IW-1:0]        IDX_LAST   = IW'(NFFT - 1);
    localparam logic [IW-1:0]        PILOT_MASK = IW'(PILOT_STEP - 1);
    localparam logic [SW-1:0]        SYM_LAST   = SW'(FRAME_SYMS - 1);
    localparam logic signed [DW-1:0] NEG_AMP    = -AMP;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [SW-1:0]  sym_q;

    logic adv;
    logic is_pilot;
    logic last_idx;
    logic emit;
    logic emit_pilot;
    logic lfsr_load;
    logic sign;

    assign adv      = !out_valid || out_ready;
    assign is_pilot = (idx_q & PILOT_MASK) == '0;
    assign last_idx = idx_q == IDX_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        emit       = 1'b0;
        emit_pilot = 1'b0;
        lfsr_load  = 1'b0;
        case (state_q)
            IDLE: begin
                // The waiting sample only starts the frame; it is consumed in DATA.
                if (in_valid) begin
                    state_d   = PRE;
                    lfsr_load = 1'b1;
                end
            end
            PRE: begin
                if (adv) begin
                    emit       = 1'b1;
                    emit_pilot = 1'b1;
                    if (last_idx) state_d = DATA;
                end
            end
            DATA: begin
                if (is_pilot) begin
                    emit       = adv;
                    emit_pilot = adv;
                end else begin
                    in_ready = adv;
                    emit     = adv && in_valid;
                end
                if (emit && last_idx && sym_q == SYM_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            sym_q <= '0;
        end else if (emit) begin
            idx_q <= last_idx ? '0 : idx_q + IW'(1);
            if (state_q == DATA && last_idx) begin
                sym_q <= (sym_q == SYM_LAST) ? '0 : sym_q + SW'(1);
            end
        end
    end

    tx_lfsr7 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .adv   (emit_pilot),
        .bit_o (sign)
    );

    // Payload fields keep their last value when a bubble clears out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_idx   <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_pilot <= 1'b0;
            out_pre   <= 1'b0;
        end else if (adv) begin
            out_valid <= emit;
            if (emit) begin
                out_i     <= emit_pilot ? (sign ? NEG_AMP : AMP) : in_i;
                out_q     <= emit_pilot ? '0 : in_q;
                out_idx   <= idx_q;
                out_sop   <= idx_q == '0;
                out_eop   <= last_idx;
                out_pilot <= emit_pilot;
                out_pre   <= state_q == PRE;
            end
        end
    end

endmodule

// File: tb/tb_pilot_inserter.sv
// Directed bench for pilot_inserter: frame layout, pilot signs, backpressure,
// input gaps and mid-frame reset, checked against a frame-position scoreboard.
module tb_pilot_inserter;

    localparam int NFFT  = 64;
    localparam int STEP  = 8;
    localparam int NSYM  = 4;
    localparam int FRAME = NFFT * (NSYM + 1);
    localparam int NDATA = NSYM * (NFFT - NFFT / STEP);

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] in_i, in_q;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_i, out_q;
    logic               out_valid;
    logic               out_ready;
    logic               out_sop, out_eop;
    logic [5:0]         out_idx;
    logic               out_pilot, out_pre;

    always #5 clk = ~clk;

    pilot_inserter #(
        .DW         (16),
        .NFFT       (NFFT),
        .PILOT_STEP (STEP),
        .FRAME_SYMS (NSYM),
        .AMP        (16'sd8192)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_i      (in_i),
        .in_q      (in_q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_idx   (out_idx),
        .out_pilot (out_pilot),
        .out_pre   (out_pre)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string tag, input longint got, input longint want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Golden pilot signs: x^7+x^6+1 from seed 7F; first eight worked by hand.
    bit gold[0:FRAME-1];
    bit hand_sign[0:7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [6:0] s;
        s = 7'h7F;
        for (int n = 0; n < FRAME; n++) begin
            gold[n] = s[0];
            s = {s[5:0], s[6] ^ s[5]};
        end
    end

    // Driver state
    bit drv_on = 0;
    bit vmode  = 0;
    bit rmode  = 0;
    int budget = 0;
    int samp   = 0;
    int gap    = 0;
    bit took   = 0;

    // Monitor / scoreboard state
    bit          mon_en     = 0;
    bit          prev_stall = 0;
    logic [42:0] hold_vec;
    logic [42:0] cur_vec;
    logic [31:0] sb[$];
    int pos = 0, pc = 0, frames = 0, outs = 0, bubbles = 0, stalls = 0;

    assign cur_vec = {out_i, out_q, out_idx, out_sop, out_eop, out_pilot, out_pre, out_valid};

    initial forever begin
        @(posedge clk);
        #1;
        if (took) begin
            samp++;
            took = 0;
            gap  = 0;
        end
        in_i = 16'(samp * 37 + 100);
        in_q = 16'(-(samp * 11) - 5);
        if (!drv_on) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end else begin
            out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (samp >= budget) begin
                in_valid = 1'b0;
            end else if (vmode && (samp % (NFFT - NFFT / STEP)) == 4 && gap < 3) begin
                in_valid = 1'b0;
                gap++;
            end else begin
                in_valid = 1'b1;
            end
        end
    end

    task automatic model_check();
        int  idx;
        bit  pre, pil;
        logic [31:0] d;
        idx = pos % NFFT;
        pre = pos < NFFT;
        pil = pre || (idx % STEP) == 0;
        check("idx", out_idx, idx);
        check("pre", out_pre, pre);
        check("pilot", out_pilot, pil);
        check("sop", out_sop, idx == 0);
        check("eop", out_eop, idx == NFFT - 1);
        if (pil) begin
            check("pilot_i", out_i, gold[pc] ? -8192 : 8192);
            check("pilot_q", out_q, 0);
            if (pc < 8) check("pre_hand_sign", out_i, hand_sign[pc] ? -8192 : 8192);
            pc++;
        end else if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            d = sb.pop_front();
            check("data_i", out_i, $signed(d[31:16]));
            check("data_q", out_q, $signed(d[15:0]));
        end
        outs++;
        pos++;
        if (pos == FRAME) begin
            pos = 0;
            pc  = 0;
            frames++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (prev_stall) check("hold", cur_vec, hold_vec);
            if (out_valid && out_ready) model_check();
            else if (!out_valid && pos > 0) bubbles++;
            if (in_valid && in_ready) begin
                sb.push_back({in_i, in_q});
                took = 1;
            end
            prev_stall = out_valid && !out_ready;
            hold_vec   = cur_vec;
            if (prev_stall) stalls++;
        end
    end

    task automatic start_test(input int bud, input bit vm, input bit rm);
        mon_en = 0;
        sb.delete();
        pos = 0; pc = 0; frames = 0; outs = 0; bubbles = 0; stalls = 0;
        samp = 0; gap = 0; took = 0; prev_stall = 0;
        budget = bud; vmode = vm; rmode = rm;
        mon_en = 1;
        drv_on = 1;
    endtask

    task automatic wait_frames(input string tag, input int n, input int bound);
        for (int c = 0; c < bound && frames < n; c++) @(posedge clk);
        check(tag, frames, n);
        drv_on = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_i"}, out_i, 0);
        check({tag, "_q"}, out_q, 0);
        check({tag, "_flags"}, {out_idx, out_sop, out_eop, out_pilot, out_pre}, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no input: nothing leaves, nothing is accepted.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
        end
        check_zero("idle");

        // Two back-to-back frames with continuous input and no backpressure.
        start_test(2 * NDATA, 0, 0);
        wait_frames("two_frames", 2, 2000);
        check("two_frames_outs", outs, 2 * FRAME);
        check("two_frames_samples", samp, 2 * NDATA);
        repeat (10) @(negedge clk);
        check("after_idle_valid", out_valid, 0);
        check("after_idle_in_ready", in_ready, 0);
        check("after_idle_outs", outs, 2 * FRAME);

        // Random backpressure.
        start_test(NDATA, 0, 1);
        wait_frames("bp_frame", 1, 4000);
        check("bp_outs", outs, FRAME);
        check("bp_sb_empty", sb.size(), 0);
        check("bp_stalls_seen", stalls > 0, 1);

        // Input gap of three cycles at idx 5 of each data symbol.
        start_test(NDATA, 1, 0);
        wait_frames("gap_frame", 1, 2000);
        check("gap_bubbles", bubbles, 3 * NSYM);
        check("gap_outs", outs, FRAME);

        // Reset mid data symbol 2, then a clean restart.
        start_test(NDATA, 0, 0);
        for (int c = 0; c < 2000 && pos < 2 * NFFT + NFFT + 30; c++) begin
            @(posedge clk);
            #3;
        end
        check("rst_reached_pos", pos >= 2 * NFFT + NFFT + 30, 1);
        mon_en = 0;
        drv_on = 0;
        rst_n  = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_test(NDATA, 0, 0);
        wait_frames("restart_frame", 1, 2000);
        check("restart_outs", outs, FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
